voice_scheduler: RTL and testbench
==================================

// Module: voice_scheduler
// PURPOSE
//  Time-multiplexes the shared DDS phase datapath across NV voices. Holds one
//  phase-increment register per voice and, once per sample tick, issues one
//  slot per voice in fixed order 0..NV-1 to the shared accumulator.
//  Replaces static per-voice routing with a sequenced valid/ready stream.
//  Sits between the control/register interface and the phase accumulator.
// PARAMETERS
//  M   12  phase-increment width (bits)
//  SW  2   voice-select width; NV = 1<<SW voices
// PORTS
//  clk         in   1     system clock, all state on rising edge
//  rst         in   1     asynchronous, active-high reset
//  wr_en       in   1     write strobe for increment register file
//  wr_sel      in   SW    voice index to write
//  wr_data     in   M     increment value
//  en_mask     in   NV    voice enables, bit i = voice i
//  sample_tick in   1     one-cycle pulse, start of frame
//  dp_ready    in   1     datapath accepts current slot
//  out_valid   out  1     slot valid
//  out_sel     out  SW    voice index of slot
//  out_incr    out  M     increment of slot
//  frame_done  out  1     one-cycle pulse, frame complete
//  overrun     out  1     sticky tick-while-busy flag (macro only, else 0)
// BEHAVIOUR
//  Reset: all increment regs 0; out_valid=0, out_sel=0, out_incr=0,
//   frame_done=0, overrun=0; FSM=IDLE, idx=0.
//  Writes: accepted every cycle in any state; reg[wr_sel]<=wr_data at edge.
//  FSM IDLE -> SCAN on sample_tick: snap<=en_mask, idx<=0.
//  SCAN, per edge unless stalled: out_valid<=snap[idx]; out_sel<=idx;
//   out_incr<=reg[idx] (pre-edge value; same-cycle write to idx not seen);
//   idx<=idx+1; at idx==NV-1 -> DONE.
//  Disabled voice = bubble slot: out_valid=0, out_sel/out_incr still update.
//   Slot timing is fixed whether or not voices are enabled.
//  Stall: out_valid=1 && dp_ready=0 -> idx, out_* and FSM hold.
//   Slot is consumed on the edge where out_valid && dp_ready.
//   Bubbles never stall.
//  DONE: on the edge leaving DONE, out_valid<=0 unless stalled on the last
//   slot; frame_done<=1 for exactly one cycle; -> IDLE. frame_done is
//   raised only after the last valid slot is consumed.
//  Latency, no stalls: tick sampled at edge E0; slot i outputs after E(i+1);
//   frame_done high after E(NV+1). Next tick accepted from the cycle
//   frame_done is high (FSM already IDLE).
//  sample_tick in SCAN/DONE: ignored, frame continues unaffected.
//  en_mask changes mid-frame: no effect until next tick (snapshot).
//  en_mask=0: full frame of NV bubbles, frame_done still pulses.
//  Async reset mid-frame: immediate return to reset values; slot dropped.
// CONFIGURATION
//  VSCHED_OVERRUN_EN defined: overrun<=1 when sample_tick is seen in SCAN
//   or DONE. Stays set until reset. Adds no change to slot timing.
//  Not defined: overrun tied 0, no detection logic.
// TESTING
//  1 Reset, then write regs 0..3 = 0x011,0x022,0x033,0x044, mask=4'hF, one
//    tick, dp_ready=1 -> slots sel 0..3 with incr 0x011..0x044 on 4
//    consecutive cycles, then frame_done pulse.
//  2 mask=4'b0101, tick -> valid only on sel 0 and 2; bubbles on 1 and 3;
//    frame_done at the same cycle as test 1.
//  3 dp_ready=0 for 3 cycles while slot 1 valid -> sel=1, incr=0x022 held
//    for 3 cycles; slot 2 follows the release; frame_done is delayed by 3.
//  4 Write reg1=0x0AA on the same edge slot 1 is issued -> slot shows
//    0x022; next frame shows 0x0AA.
//  5 Second tick during SCAN -> ignored, frame unchanged; with
//    VSCHED_OVERRUN_EN overrun=1 until rst, without it overrun=0.
//  6 Assert rst mid-SCAN -> all outputs 0 immediately; next tick starts
//    at sel 0 with incr 0.

Source files
------------

// File: rtl/voice_scheduler.sv
// voice_scheduler
//   Shares one DDS phase datapath among NV = 1<<SW voices. The block keeps
//   one phase-increment register per voice. On each sample tick it issues
//   one slot per voice, in fixed order 0..NV-1, as a valid/ready stream to
//   the shared accumulator.
//
//   Optional feature: define VSCHED_OVERRUN_EN to add a sticky overrun flag.
//   The flag sets when sample_tick arrives while a frame is still running.
//   Without the macro, overrun is tied to 0.
//
// Ports
//   clk         in   1    system clock, rising edge
//   rst         in   1    asynchronous active-high reset
//   wr_en       in   1    increment register write strobe
//   wr_sel      in   SW   voice index to write
//   wr_data     in   M    increment value
//   en_mask     in   NV   voice enables, bit i = voice i
//   sample_tick in   1    one-cycle frame start pulse
//   dp_ready    in   1    datapath accepts the current slot
//   out_valid   out  1    slot valid (0 = bubble for a disabled voice)
//   out_sel     out  SW   voice index of the slot
//   out_incr    out  M    increment of the slot
//   frame_done  out  1    one-cycle pulse after the last slot is consumed
//   overrun     out  1    sticky tick-while-busy flag

module voice_scheduler #(
    parameter int M  = 12,
    parameter int SW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [SW-1:0]        wr_sel,
    input  logic [M-1:0]         wr_data,
    input  logic [(1<<SW)-1:0]   en_mask,
    input  logic                 sample_tick,
    input  logic                 dp_ready,
    output logic                 out_valid,
    output logic [SW-1:0]        out_sel,
    output logic [M-1:0]         out_incr,
    output logic                 frame_done,
    output logic                 overrun
);

    localparam int            NV   = 1 << SW;
    localparam logic [SW-1:0] LAST = SW'(NV - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state_q;
    logic [SW-1:0]   idx_q;
    logic [NV-1:0]   snap_q;
    logic [M-1:0]    incr_q [NV];
    logic            out_valid_q;
    logic [SW-1:0]   out_sel_q;
    logic [M-1:0]    out_incr_q;
    logic            frame_done_q;

    // A valid slot that the datapath refuses freezes the sequencer.
    // Bubbles carry out_valid=0, so they can never stall.
    logic stall;
    assign stall = out_valid_q && !dp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NV; i++) begin
                incr_q[i] <= '0;
            end
            state_q      <= IDLE;
            idx_q        <= '0;
            snap_q       <= '0;
            out_valid_q  <= 1'b0;
            out_sel_q    <= '0;
            out_incr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            // The register file takes writes in every state. A slot issued on
            // the same edge reads the pre-edge value.
            if (wr_en) begin
                incr_q[wr_sel] <= wr_data;
            end

            frame_done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (sample_tick) begin
                        // Snapshot the enables. Mask changes mid-frame wait
                        // for the next tick.
                        snap_q  <= en_mask;
                        idx_q   <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (!stall) begin
                        out_valid_q <= snap_q[idx_q];
                        out_sel_q   <= idx_q;
                        out_incr_q  <= incr_q[idx_q];
                        idx_q       <= idx_q + 1'b1;
                        if (idx_q == LAST) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // The last slot is on the outputs. Signal completion
                    // only once that slot has been consumed.
                    if (!stall) begin
                        out_valid_q  <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sel    = out_sel_q;
    assign out_incr   = out_incr_q;
    assign frame_done = frame_done_q;

`ifdef VSCHED_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (sample_tick && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;

    localparam int M  = 12;
    localparam int SW = 2;
    localparam int NV = 1 << SW;

`ifdef VSCHED_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [SW-1:0]   wr_sel;
    logic [M-1:0]    wr_data;
    logic [NV-1:0]   en_mask;
    logic            sample_tick;
    logic            dp_ready;
    logic            out_valid;
    logic [SW-1:0]   out_sel;
    logic [M-1:0]    out_incr;
    logic            frame_done;
    logic            overrun;

    int n_cmp = 0;
    int n_err = 0;

    voice_scheduler #(.M(M), .SW(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .en_mask     (en_mask),
        .sample_tick (sample_tick),
        .dp_ready    (dp_ready),
        .out_valid   (out_valid),
        .out_sel     (out_sel),
        .out_incr    (out_incr),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic v, input logic [SW-1:0] s,
                            input logic [M-1:0] inc);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".sel"},   32'(out_sel),   32'(s));
        chk({tag, ".incr"},  32'(out_incr),  32'(inc));
    endtask

    task automatic wr(input logic [SW-1:0] s, input logic [M-1:0] d);
        wr_en = 1'b1; wr_sel = s; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Pulse sample_tick across one edge (E0).
    task automatic tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
        en_mask = '0; sample_tick = 1'b0; dp_ready = 1'b1;
        step(); step();
        chk("rst.valid", 32'(out_valid), 0);
        chk("rst.sel", 32'(out_sel), 0);
        chk("rst.incr", 32'(out_incr), 0);
        chk("rst.fdone", 32'(frame_done), 0);
        chk("rst.ovr", 32'(overrun), 0);
        rst = 1'b0;
        step();

        // Test 1: all voices enabled, no stalls.
        wr(2'd0, 12'h011); wr(2'd1, 12'h022); wr(2'd2, 12'h033); wr(2'd3, 12'h044);
        en_mask = 4'hF;
        tick();
        step(); chk_slot("t1.s0", 1'b1, 2'd0, 12'h011); chk("t1.fd_s0", 32'(frame_done), 0);
        step(); chk_slot("t1.s1", 1'b1, 2'd1, 12'h022);
        step(); chk_slot("t1.s2", 1'b1, 2'd2, 12'h033);
        step(); chk_slot("t1.s3", 1'b1, 2'd3, 12'h044); chk("t1.fd_s3", 32'(frame_done), 0);
        step(); chk("t1.fd", 32'(frame_done), 1); chk("t1.v_end", 32'(out_valid), 0);
        step(); chk("t1.fd_off", 32'(frame_done), 0);

        // Test 2: mask 0101 gives bubbles on voices 1 and 3.
        en_mask = 4'b0101;
        tick();
        en_mask = 4'hF;     // mid-frame mask change must be ignored
        step(); chk_slot("t2.s0", 1'b1, 2'd0, 12'h011);
        step(); chk_slot("t2.s1", 1'b0, 2'd1, 12'h022);
        step(); chk_slot("t2.s2", 1'b1, 2'd2, 12'h033);
        step(); chk_slot("t2.s3", 1'b0, 2'd3, 12'h044);
        step(); chk("t2.fd", 32'(frame_done), 1);
        step();

        // Test 3: three-cycle stall on slot 1.
        tick();
        step(); chk_slot("t3.s0", 1'b1, 2'd0, 12'h011);
        step(); chk_slot("t3.s1", 1'b1, 2'd1, 12'h022);
        dp_ready = 1'b0;
        step(); chk_slot("t3.h1", 1'b1, 2'd1, 12'h022);
        step(); chk_slot("t3.h2", 1'b1, 2'd1, 12'h022);
        step(); chk_slot("t3.h3", 1'b1, 2'd1, 12'h022); chk("t3.fd_h3", 32'(frame_done), 0);
        dp_ready = 1'b1;
        step(); chk_slot("t3.s2", 1'b1, 2'd2, 12'h033);
        step(); chk_slot("t3.s3", 1'b1, 2'd3, 12'h044); chk("t3.fd_s3", 32'(frame_done), 0);
        step(); chk("t3.fd", 32'(frame_done), 1);
        step();

        // Test 4: write reg1 on the edge that issues slot 1.
        tick();
        step(); chk_slot("t4.s0", 1'b1, 2'd0, 12'h011);
        wr_en = 1'b1; wr_sel = 2'd1; wr_data = 12'h0AA;
        step(); wr_en = 1'b0;
        chk_slot("t4.s1", 1'b1, 2'd1, 12'h022);
        step(); step(); step();
        chk("t4.fd", 32'(frame_done), 1);
        step();
        tick();
        step(); step(); chk_slot("t4.n1", 1'b1, 2'd1, 12'h0AA);
        step(); step(); step(); chk("t4.nfd", 32'(frame_done), 1);
        step();
        chk("t5.ovr_pre", 32'(overrun), 0);

        // Test 5: second tick during SCAN is ignored.
        tick();
        step(); chk_slot("t5.s0", 1'b1, 2'd0, 12'h011);
        sample_tick = 1'b1;
        step(); sample_tick = 1'b0;
        chk_slot("t5.s1", 1'b1, 2'd1, 12'h0AA);
        step(); chk_slot("t5.s2", 1'b1, 2'd2, 12'h033);
        step(); chk_slot("t5.s3", 1'b1, 2'd3, 12'h044);
        step(); chk("t5.fd", 32'(frame_done), 1);
        step(); chk("t5.idle_v", 32'(out_valid), 0); chk("t5.ovr", 32'(overrun), 32'(OVR_EXP));

        // Test 6: async reset mid-SCAN.
        tick();
        step(); step(); chk_slot("t6.s1", 1'b1, 2'd1, 12'h0AA);
        #2 rst = 1'b1;
        #1;
        chk_slot("t6.rst", 1'b0, 2'd0, 12'h000);
        chk("t6.rst_fd", 32'(frame_done), 0);
        chk("t6.rst_ovr", 32'(overrun), 0);
        step();
        rst = 1'b0;
        step();
        tick();
        step(); chk_slot("t6.n0", 1'b1, 2'd0, 12'h000);
        step(); chk_slot("t6.n1", 1'b1, 2'd1, 12'h000);
        step(); step(); step(); chk("t6.nfd", 32'(frame_done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
